// File: rtl/univ_ff_pkg.sv
// Shared mode encoding for the universal flip-flop register.
// The mode type and its named values are used by the datapath and by the top level.
package univ_ff_pkg;

    typedef logic [2:0] ff_mode_t;

    localparam ff_mode_t MODE_HOLD = 3'b000;
    localparam ff_mode_t MODE_D    = 3'b001;
    localparam ff_mode_t MODE_T    = 3'b010;
    localparam ff_mode_t MODE_JK   = 3'b011;
    localparam ff_mode_t MODE_SR   = 3'b100;
    localparam ff_mode_t MODE_SHL  = 3'b101;
    localparam ff_mode_t MODE_SHR  = 3'b110;
    localparam ff_mode_t MODE_ROL  = 3'b111;

endpackage

// File: rtl/univ_ff_next.sv
// Combinational next-state logic for the universal flip-flop register.
// Produces the next state, the next serial-out bit and the SR conflict indication.
module univ_ff_next
    import univ_ff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  ff_mode_t         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] qs,
    input  logic             ser_q,
    output logic [WIDTH-1:0] next,
    output logic             ser_next,
    output logic             sr_conflict
);

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_sr_set;
    logic [WIDTH-1:0] w_sr_clr;

    // A single bit has no neighbours: shifts load ser_in and rotate holds.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shl = ser_in;
            assign w_shr = ser_in;
            assign w_rol = qs;
        end else begin : g_wn
            assign w_shl = {qs[WIDTH-2:0], ser_in};
            assign w_shr = {ser_in, qs[WIDTH-1:1]};
            assign w_rol = {qs[WIDTH-2:0], qs[WIDTH-1]};
        end
    endgenerate

    assign w_sr_set = a & ~b;
    assign w_sr_clr = b & ~a;

    // Mode decode; S=R=1 bits fall through both masks and hold.
    always_comb begin
        next        = qs;
        ser_next    = ser_q;
        sr_conflict = 1'b0;
        case (mode)
            MODE_HOLD: next = qs;
            MODE_D:    next = a;
            MODE_T:    next = qs ^ a;
            MODE_JK:   next = (a & ~qs) | (~b & qs);
            MODE_SR: begin
                next        = (qs | w_sr_set) & ~w_sr_clr;
                sr_conflict = |(a & b);
            end
            MODE_SHL: begin
                next     = w_shl;
                ser_next = qs[WIDTH-1];
            end
            MODE_SHR: begin
                next     = w_shr;
                ser_next = qs[0];
            end
            MODE_ROL: begin
                next     = w_rol;
                ser_next = qs[WIDTH-1];
            end
            default: begin
                next        = qs;
                ser_next    = ser_q;
                sr_conflict = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_ff_reg.sv
// Universal WIDTH-bit flip-flop register: hold, D, T, JK, SR, shifts and rotate.
// qm is the combinational master view; qs, ser_out and err are registered.
module univ_ff_reg
    import univ_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ser_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] qm,
    output logic [WIDTH-1:0] qs,
    output logic [WIDTH-1:0] qs_bar,
    output logic             ser_out,
    output logic             err
);

    logic [WIDTH-1:0] r_qs;
    logic             r_ser;
    logic             r_err;
    logic [WIDTH-1:0] w_next;
    logic             w_ser_next;
    logic             w_sr_conflict;

    univ_ff_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .mode       (ff_mode_t'(mode)),
        .a          (a),
        .b          (b),
        .ser_in     (ser_in),
        .qs         (r_qs),
        .ser_q      (r_ser),
        .next       (w_next),
        .ser_next   (w_ser_next),
        .sr_conflict(w_sr_conflict)
    );

    // Master view: exactly what qs will take at the next edge.
    always_comb begin
        if (rst) begin
            qm = RESET_VAL;
        end else if (en) begin
            qm = w_next;
        end else begin
            qm = r_qs;
        end
    end

    // State, serial-out and sticky error registers; a new conflict beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qs  <= RESET_VAL;
            r_ser <= 1'b0;
            r_err <= 1'b0;
        end else if (en) begin
            r_qs  <= w_next;
            r_ser <= w_ser_next;
            if (w_sr_conflict) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end else begin
            r_qs  <= r_qs;
            r_ser <= r_ser;
            r_err <= r_err;
        end
    end

    assign qs      = r_qs;
    assign qs_bar  = ~r_qs;
    assign ser_out = r_ser;
    assign err     = r_err;

endmodule

// File: tb/tb_univ_ff_reg.sv
// Directed self-checking bench for univ_ff_reg (WIDTH=8, RESET_VAL=8'h00).
module tb_univ_ff_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       ser_in;
    logic       clr_err;
    logic [7:0] qm;
    logic [7:0] qs;
    logic [7:0] qs_bar;
    logic       ser_out;
    logic       err;

    int checks;
    int failures;

    univ_ff_reg #(
        .WIDTH    (8),
        .RESET_VAL(8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .ser_in (ser_in),
        .clr_err(clr_err),
        .qm     (qm),
        .qs     (qs),
        .qs_bar (qs_bar),
        .ser_out(ser_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rol_qs [8];
        logic       rol_so [8];
        checks   = 0;
        failures = 0;
        rol_qs = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        rol_so = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with D/a=FF pending
        rst = 1'b1; en = 1'b1; mode = 3'b001; a = 8'hFF; b = 8'h00;
        ser_in = 1'b0; clr_err = 1'b0;
        #1;
        chk("qm_in_reset", qm, 8'h00);
        tick();
        tick();
        chk("rst_qs", qs, 8'h00);
        chk("rst_qs_bar", qs_bar, 8'hFF);
        chk("rst_qm", qm, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        chk("rst_ser_out", {7'd0, ser_out}, 8'h00);

        // D then T then disabled
        rst = 1'b0; mode = 3'b001; a = 8'hA5;
        tick();
        chk("d_load", qs, 8'hA5);
        chk("d_qs_bar", qs_bar, 8'h5A);
        mode = 3'b010; a = 8'h0F;
        tick();
        chk("t_toggle", qs, 8'hAA);
        en = 1'b0; a = 8'hFF;
        #1;
        chk("en0_qm", qm, 8'hAA);
        tick();
        chk("en0_hold", qs, 8'hAA);

        // JK from AA: j=F0 k=3C -> set,set,tgl,tgl,clr,clr,hold,hold = D2
        en = 1'b1; mode = 3'b011; a = 8'hF0; b = 8'h3C;
        #1;
        chk("jk_qm", qm, 8'hD2);
        tick();
        chk("jk_qs", qs, 8'hD2);

        // SR conflict handling
        mode = 3'b001; a = 8'h00; b = 8'h00;
        tick();
        chk("sr_pre_clear", qs, 8'h00);
        mode = 3'b100; a = 8'h81; b = 8'h01;
        tick();
        chk("sr_qs", qs, 8'h80);
        chk("sr_err_set", {7'd0, err}, 8'h01);
        a = 8'h00; b = 8'h00;
        tick();
        chk("sr_err_sticky", {7'd0, err}, 8'h01);
        chk("sr_hold", qs, 8'h80);
        mode = 3'b000; clr_err = 1'b1;
        tick();
        chk("err_cleared", {7'd0, err}, 8'h00);
        mode = 3'b100; a = 8'h01; b = 8'h01;
        tick();
        chk("err_set_wins", {7'd0, err}, 8'h01);
        chk("sr_both_hold", qs, 8'h80);
        mode = 3'b000; a = 8'h00; b = 8'h00;
        tick();
        chk("err_cleared2", {7'd0, err}, 8'h00);
        en = 1'b0; clr_err = 1'b0; mode = 3'b100; a = 8'hFF; b = 8'hFF;
        tick();
        chk("en0_no_conflict", {7'd0, err}, 8'h00);
        chk("en0_sr_qs", qs, 8'h80);

        // Shifts and rotate
        en = 1'b1; mode = 3'b001; a = 8'h81; b = 8'h00;
        tick();
        chk("load_81", qs, 8'h81);
        chk("d_ser_hold", {7'd0, ser_out}, 8'h00);
        mode = 3'b101; ser_in = 1'b0;
        tick();
        chk("shl_qs", qs, 8'h02);
        chk("shl_ser", {7'd0, ser_out}, 8'h01);
        mode = 3'b110; ser_in = 1'b1;
        tick();
        chk("shr_qs", qs, 8'h81);
        chk("shr_ser", {7'd0, ser_out}, 8'h00);
        mode = 3'b111; ser_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rol_qs_%0d", i), qs, rol_qs[i]);
            chk($sformatf("rol_ser_%0d", i), {7'd0, ser_out}, {7'd0, rol_so[i]});
        end
        mode = 3'b001; a = 8'h55;
        tick();
        chk("d_keeps_ser", {7'd0, ser_out}, 8'h01);

        // Reset in the middle of shifting
        mode = 3'b101; ser_in = 1'b1;
        tick();
        chk("shl_mid", qs, 8'hAB);
        chk("shl_mid_ser", {7'd0, ser_out}, 8'h00);
        ser_in = 1'b0;
        tick();
        chk("shl_mid2", qs, 8'h56);
        chk("shl_mid2_ser", {7'd0, ser_out}, 8'h01);
        rst = 1'b1;
        #1;
        chk("rst_qm_mid", qm, 8'h00);
        tick();
        chk("rst_mid_qs", qs, 8'h00);
        chk("rst_mid_ser", {7'd0, ser_out}, 8'h00);
        rst = 1'b0; ser_in = 1'b1;
        tick();
        chk("post_rst_shl", qs, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
